// File: rtl/paddle_pkg.sv
// Shared types and constants for the breakout paddle controller.
// Holds the FSM state and key-direction enums, screen geometry and small
// elaboration-time helpers used by paddle_ctrl and key_repeat.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } paddle_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT
    } paddle_dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Pixel coordinate widths and the width used for overflow-free step maths.
    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int CALC_W = 11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Both keys (or neither) cancel out to no movement.
    function automatic paddle_dir_t key_dir(input logic l, input logic r);
        if (l && !r) begin
            return DIR_LEFT;
        end else if (r && !l) begin
            return DIR_RIGHT;
        end
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Key/pixel bus between the video/keyboard side and the paddle controller.
// master: drives keys and the scan position; slave: returns paddle flag and edges.
interface paddle_ctrl_if;
    import paddle_pkg::*;

    logic           L;
    logic           R;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           paddle;
    logic [X_W-1:0] x1;
    logic [X_W-1:0] x2;

    modport master (
        output L,
        output R,
        output x,
        output y,
        input  paddle,
        input  x1,
        input  x2
    );

    modport slave (
        input  L,
        input  R,
        input  x,
        input  y,
        output paddle,
        output x1,
        output x2
    );

endinterface

// File: rtl/key_repeat.sv
// Press/hold-to-repeat engine: turns a key direction level into step pulses.
// A first press steps at once, a held key repeats after REPEAT_DLY cycles and
// then every REPEAT_RATE cycles. step_pulse is decided combinationally from
// the current state so the position register can take it on the same edge.
// Optional feature macro: PADDLE_ACCEL_EN (step doubles after ACCEL_CNT repeats).
module key_repeat
    import paddle_pkg::*;
#(
    parameter int REPEAT_DLY  = 12_500_000,
    parameter int REPEAT_RATE = 2_500_000
`ifdef PADDLE_ACCEL_EN
    ,
    parameter int ACCEL_CNT   = 4
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  paddle_dir_t dir,
    output logic        step_pulse,
    output paddle_dir_t step_dir,
    output logic        step_dbl
);

    localparam int CNT_W = max_int(1, $clog2(max_int(REPEAT_DLY, REPEAT_RATE)));
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    paddle_state_t    state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    paddle_dir_t      dir_q_reg;
    // Cleared by a key held through reset; set once the keys are seen released,
    // so a held key is not mistaken for a fresh press.
    logic             armed_reg;

    // Every step goes the way the keys currently point.
    assign step_dir = dir;

    // State, timer, direction history and press-arming registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dir_q_reg <= DIR_NONE;
            armed_reg <= (dir == DIR_NONE);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_q_reg <= dir;
            armed_reg <= armed_reg | (dir == DIR_NONE);
        end
    end

    // Next state, hold timer and step decision.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        step_pulse = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dir != DIR_NONE && armed_reg) begin
                    step_pulse = 1'b1;
                    cnt_next   = '0;
                    state_next = DELAY;
                end
            end
            DELAY: begin
                if (dir == DIR_NONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (dir != dir_q_reg) begin
                    step_pulse = 1'b1;
                    cnt_next   = '0;
                end else if (cnt_reg == DLY_LAST) begin
                    step_pulse = 1'b1;
                    cnt_next   = '0;
                    state_next = REPEAT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            REPEAT: begin
                if (dir == DIR_NONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (dir != dir_q_reg) begin
                    step_pulse = 1'b1;
                    cnt_next   = '0;
                    state_next = DELAY;
                end else if (cnt_reg == RATE_LAST) begin
                    step_pulse = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef PADDLE_ACCEL_EN
    localparam int RCNT_W = max_int(1, $clog2(ACCEL_CNT + 1));
    localparam logic [RCNT_W-1:0] RCNT_TOP = RCNT_W'(ACCEL_CNT);

    logic [RCNT_W-1:0] rcnt_reg, rcnt_next;
    logic              rpt_step;

    // A repeat step is any step that lands (or stays) in REPEAT; the step taken
    // on a direction change goes back to DELAY and is never doubled.
    assign rpt_step = step_pulse && (state_next == REPEAT);
    assign step_dbl = rpt_step && (rcnt_reg == RCNT_TOP);

    // Saturating count of repeat steps; cleared whenever the hold is broken.
    always_comb begin
        rcnt_next = rcnt_reg;
        if (state_next != REPEAT) begin
            rcnt_next = '0;
        end else if (rpt_step && rcnt_reg != RCNT_TOP) begin
            rcnt_next = rcnt_reg + 1'b1;
        end
    end

    // Repeat-count register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rcnt_reg <= '0;
        end else begin
            rcnt_reg <= rcnt_next;
        end
    end
`else
    assign step_dbl = 1'b0;
`endif

endmodule

// File: rtl/paddle_ctrl.sv
// Breakout paddle position controller.
// Keeps the paddle span [x1,x2) inside [X_LEFT,X_RIGHT), moves it on step
// pulses from key_repeat and flags pixels that fall on the paddle.
// Optional feature macro: PADDLE_ACCEL_EN (double step after ACCEL_CNT repeats).
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int PADDLE_W    = 80,
    parameter int STEP        = 30,
    parameter int X_LEFT      = 30,
    parameter int X_RIGHT     = 610,
    parameter int INIT_X1     = 280,
    parameter int Y_TOP       = 451,
    parameter int Y_BOT       = 460,
    parameter int REPEAT_DLY  = 12_500_000,
    parameter int REPEAT_RATE = 2_500_000,
    parameter int ACCEL_CNT   = 4
) (
    input logic          clk,
    input logic          reset_n,
    paddle_ctrl_if.slave bus
);

    // Legal x1 range; the right limit can never exceed the visible screen.
    localparam int X1_LO = X_LEFT;
    localparam int X1_HI = min_int(X_RIGHT, SCREEN_W) - PADDLE_W;
    localparam int Y_END = min_int(Y_BOT, SCREEN_H);

    localparam logic [X_W-1:0]    STEP_1X  = X_W'(STEP);
    localparam logic [X_W-1:0]    STEP_2X  = X_W'(2 * STEP);
    localparam logic [CALC_W-1:0] X1_LO_W  = CALC_W'(X1_LO);
    localparam logic [CALC_W-1:0] X1_HI_W  = CALC_W'(X1_HI);

    paddle_dir_t        key_dir_w;
    logic               step_pulse;
    paddle_dir_t        step_dir;
    logic               step_dbl;
    logic [X_W-1:0]     step_x;
    logic [CALC_W-1:0]  sum_wide;
    logic [CALC_W-1:0]  left_lim;
    logic [X_W-1:0]     x1_reg, x1_next, x2_reg;

    assign key_dir_w = key_dir(bus.L, bus.R);

    key_repeat #(
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
`ifdef PADDLE_ACCEL_EN
        ,
        .ACCEL_CNT   (ACCEL_CNT)
`endif
    ) u_key_repeat (
        .clk        (clk),
        .reset_n    (reset_n),
        .dir        (key_dir_w),
        .step_pulse (step_pulse),
        .step_dir   (step_dir),
        .step_dbl   (step_dbl)
    );

    // Clamped next position; bounds are checked in 11 bits so nothing wraps.
    always_comb begin
        step_x   = step_dbl ? STEP_2X : STEP_1X;
        sum_wide = {1'b0, x1_reg} + {1'b0, step_x};
        left_lim = X1_LO_W + {1'b0, step_x};
        x1_next  = x1_reg;
        if (step_pulse) begin
            if (step_dir == DIR_LEFT) begin
                if ({1'b0, x1_reg} < left_lim) begin
                    x1_next = X_W'(X1_LO);
                end else begin
                    x1_next = x1_reg - step_x;
                end
            end else if (step_dir == DIR_RIGHT) begin
                if (sum_wide > X1_HI_W) begin
                    x1_next = X_W'(X1_HI);
                end else begin
                    x1_next = x1_reg + step_x;
                end
            end
        end
    end

    // Paddle edge registers; x2 is kept as a register so collision logic sees a clean value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x1_reg <= X_W'(INIT_X1);
            x2_reg <= X_W'(INIT_X1 + PADDLE_W);
        end else begin
            x1_reg <= x1_next;
            x2_reg <= x1_next + X_W'(PADDLE_W);
        end
    end

    assign bus.x1     = x1_reg;
    assign bus.x2     = x2_reg;
    assign bus.paddle = (bus.x >= x1_reg) && (bus.x < x2_reg) &&
                        (bus.y >= Y_W'(Y_TOP)) && (bus.y < Y_W'(Y_END));

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl (short repeat timings).
// Stimulus pushes the reference model's expected x1/x2/paddle per cycle into
// a queue; a monitor pops one entry per clock and compares it with the DUT.
// Honours PADDLE_ACCEL_EN in the reference model.
module tb_paddle_ctrl;

    localparam int PADDLE_W    = 80;
    localparam int STEP        = 30;
    localparam int X_LEFT      = 30;
    localparam int X_RIGHT     = 610;
    localparam int INIT_X1     = 280;
    localparam int Y_TOP       = 451;
    localparam int Y_BOT       = 460;
    localparam int REPEAT_DLY  = 4;
    localparam int REPEAT_RATE = 2;
    localparam int ACCEL_CNT   = 2;

    typedef struct {
        int x1;
        int x2;
        int pad;
        int l;
        int r;
        int rn;
    } exp_t;

    logic clk = 1'b1;
    logic reset_n;
    paddle_ctrl_if bus();

    paddle_ctrl #(
        .PADDLE_W    (PADDLE_W),
        .STEP        (STEP),
        .X_LEFT      (X_LEFT),
        .X_RIGHT     (X_RIGHT),
        .INIT_X1     (INIT_X1),
        .Y_TOP       (Y_TOP),
        .Y_BOT       (Y_BOT),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE),
        .ACCEL_CNT   (ACCEL_CNT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: hold age since the current direction was pressed.
    int m_x1     = INIT_X1;
    int m_active = 0;
    int m_dir    = 0;
    int m_age    = 0;
    int m_armed  = 1;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int dir_of(input int l, input int r);
        if (l != 0 && r == 0) return 1;
        if (r != 0 && l == 0) return 2;
        return 0;
    endfunction

    task automatic model_cycle(input int l, input int r, input int rn);
        int d;
        int s;
        int step;
        int dbl;
        d    = dir_of(l, r);
        step = 0;
        dbl  = 0;
        if (rn == 0) begin
            m_x1     = INIT_X1;
            m_active = 0;
            m_age    = 0;
            m_armed  = (d == 0) ? 1 : 0;
            return;
        end
        if (d == 0) begin
            m_active = 0;
        end else if (m_active == 0) begin
            if (m_armed != 0) begin
                m_active = 1;
                m_dir    = d;
                m_age    = 0;
                step     = 1;
            end
        end else if (d != m_dir) begin
            m_dir = d;
            m_age = 0;
            step  = 1;
        end else begin
            m_age++;
            if (m_age >= REPEAT_DLY && ((m_age - REPEAT_DLY) % REPEAT_RATE) == 0) begin
                step = 1;
`ifdef PADDLE_ACCEL_EN
                if ((m_age - REPEAT_DLY) / REPEAT_RATE + 1 > ACCEL_CNT) dbl = 1;
`endif
            end
        end
        if (d == 0) m_armed = 1;
        if (step != 0) begin
            s = (dbl != 0) ? 2 * STEP : STEP;
            if (d == 1) begin
                m_x1 = (m_x1 - s < X_LEFT) ? X_LEFT : m_x1 - s;
            end else begin
                m_x1 = (m_x1 + s > X_RIGHT - PADDLE_W) ? X_RIGHT - PADDLE_W : m_x1 + s;
            end
        end
    endtask

    // One clock of stimulus: drive on the falling edge, predict the next rising edge.
    task automatic cycle(input int l, input int r, input int rn);
        exp_t e;
        int   px;
        int   py;
        @(negedge clk);
        bus.L   = (l != 0);
        bus.R   = (r != 0);
        reset_n = (rn != 0);
        model_cycle(l, r, rn);
        if ($urandom_range(0, 1) == 0) begin
            px = $urandom_range(0, 639);
        end else begin
            px = m_x1 - 2 + $urandom_range(0, PADDLE_W + 3);
        end
        py = $urandom_range(446, 464);
        bus.x = 10'(px);
        bus.y = 9'(py);
        e.x1  = m_x1;
        e.x2  = m_x1 + PADDLE_W;
        e.pad = (px >= e.x1 && px < e.x2 && py >= Y_TOP && py < Y_BOT) ? 1 : 0;
        e.l   = l;
        e.r   = r;
        e.rn  = rn;
        sb_q.push_back(e);
    endtask

    task automatic hold(input int l, input int r, input int n);
        for (int i = 0; i < n; i++) cycle(l, r, 1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d rn=%0d L=%0d R=%0d x1=%0d x2=%0d paddle=%0d (exp x1=%0d pad=%0d)",
                         txn, e.rn, e.l, e.r, bus.x1, bus.x2, bus.paddle, e.x1, e.pad);
                check("sb_x1", bus.x1, e.x1);
                check("sb_x2", bus.x2, e.x2);
                check("sb_paddle", bus.paddle, e.pad);
            end
        end
    end

    // Stimulus: directed scenarios, then randomized key patterns.
    initial begin
        int k;
        int n;
        int l;
        int r;
        bus.L   = 1'b0;
        bus.R   = 1'b0;
        bus.x   = '0;
        bus.y   = '0;
        reset_n = 1'b0;

        // Reset state and pixel compare.
        cycle(0, 0, 0);
        settle();
        check("reset_x1", bus.x1, 280);
        check("reset_x2", bus.x2, 360);
        bus.x = 10'd300; bus.y = 9'd455; #1;
        check("pix_in", bus.paddle, 1);
        bus.x = 10'd280; bus.y = 9'd450; #1;
        check("pix_above", bus.paddle, 0);
        bus.x = 10'd360; bus.y = 9'd455; #1;
        check("pix_x2_excl", bus.paddle, 0);

        // Single tap left, then keys idle.
        cycle(1, 0, 1);
        settle();
        check("tap_left", bus.x1, 250);
        check("tap_left_x2", bus.x2, 330);
        hold(0, 0, 3);
        settle();
        check("tap_no_repeat", bus.x1, 250);

        // R held 12 cycles from reset.
        cycle(0, 0, 0);
        hold(0, 1, 12);
        settle();
`ifdef PADDLE_ACCEL_EN
        check("hold_right_12", bus.x1, 490);
`else
        check("hold_right_12", bus.x1, 430);
`endif
        hold(0, 0, 1);

        // Walk to x1=40 with taps, then hold left against the boundary.
        cycle(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 1);
            cycle(0, 0, 1);
        end
        settle();
        check("taps_to_40", bus.x1, 40);
        hold(1, 0, 10);
        settle();
        check("left_clamp", bus.x1, 30);
        hold(0, 0, 1);

        // Hold right to the far end.
        hold(0, 1, 60);
        settle();
        check("right_clamp_x2", bus.x2, 610);
        hold(0, 0, 1);

        // Both keys in DELAY cancel; releasing R steps left at once.
        cycle(1, 0, 1);
        hold(1, 1, 3);
        settle();
        check("both_keys_no_step", bus.x1, 500);
        cycle(1, 0, 1);
        settle();
        check("release_r_steps", bus.x1, 470);
        hold(0, 0, 1);

        // Reset in the middle of a repeat with R still held.
        hold(0, 1, 8);
        cycle(0, 1, 0);
        hold(0, 1, 6);
        settle();
        check("held_through_reset", bus.x1, 280);
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        settle();
        check("repress_after_reset", bus.x1, 310);
        hold(0, 0, 1);

        // Randomized holds, direction changes, chords and occasional resets.
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            l = (k < 4 || k == 9) ? 1 : 0;
            r = ((k >= 4 && k < 8) || k == 9) ? 1 : 0;
            n = $urandom_range(1, 16);
            if ($urandom_range(0, 29) == 0) cycle(l, r, 0);
            hold(l, r, n);
        end

        hold(0, 0, 3);
        settle();
        @(posedge clk);
        #3;
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
